fm_sweep_wb_slave: RTL and testbench
====================================

# fm_sweep_wb_slave

Wishbone-controlled linear frequency-sweep sequencer that produces the phase-increment word driving a DDS carrier. Replaces the fixed carrier-frequency register with a programmable sweep engine: start/stop/step/dwell, up or down, one-shot, repeat or bidirectional (triangle). Sits between the Wishbone bus and the carrier DDS `i_increment` input. Behaves as a plain frequency register when no sweep is running.

## Interface
- INC_W, 31, increment width in bits (DDS accumulator width − 1)
- DWELL_W, 16, dwell counter width
- START_RST, 100000, reset value of START register and o_increment
- STOP_RST, 200000, reset value of STOP register
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone classic-pipelined strobes
- i_wb_addr  in  3  register address
- i_wb_data  in  32  write data
- o_wb_ack  out  1  acknowledge
- o_wb_stall  out  1  constant 0
- o_wb_data  out  32  registered read data
- o_increment  out  INC_W  current DDS phase increment (registered)
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle pulse at sweep completion

## Operation
- Registers: 0 START, 1 STOP, 2 STEP (unsigned, INC_W bits), 3 DWELL (DWELL_W bits), 4 CTRL, 5 STATUS (RO), 6 CUR (RO, = o_increment), 7 reads 0; unused upper bits read 0; writes to 5–7 ignored.
- CTRL: bit0 GO (self-clearing, reads 0), bit1 REPEAT, bit2 BIDIR, bit3 ABORT (self-clearing, reads 0). STATUS: bit0 busy, bit1 dir (1 = decreasing), bit2 state == DWELL.
- Reset: START=START_RST, STOP=STOP_RST, STEP=1, DWELL=0, CTRL=0, o_increment=START_RST, o_busy=0, o_done=0, o_wb_ack=0, o_wb_data=0, state IDLE.
- START/STOP/STEP/DWELL are latched into shadow registers on GO and at each REPEAT restart; bus writes during a sweep do not disturb the current pass.
- States: IDLE, DWELL, DONE.
  - IDLE → DWELL on GO: cur←START, dir←(STOP<START), target←STOP, counter←DWELL.
  - DWELL: counter decrements; at 0 evaluate the step: remaining=|target−cur|; if remaining==0, end leg; else if STEP==0 or remaining≤STEP, cur←target, else cur←cur±STEP; reload counter.
  - End of leg: if BIDIR and forward leg, reverse dir, target←START, step once toward it. Else if REPEAT, re-latch shadows; unidirectional restarts at START, bidirectional begins the next forward leg at START+STEP, so endpoints are never doubled. Otherwise → DONE.
  - DONE → IDLE after one cycle with o_done=1, o_busy=0; o_increment holds the final value.
- In IDLE, a write to START loads o_increment on the next cycle (legacy fixed-frequency mode).
- ABORT → IDLE in 1 cycle, o_increment held, no o_done. ABORT+GO in the same write: ABORT wins. GO while busy: restart from START.
- START==STOP: single value held DWELL+1 cycles, then done. Non-repeat BIDIR completes back at START.

## Timing
- Bus: o_wb_ack=1 exactly one cycle after any i_wb_stb; o_wb_data valid with ack; no stall.
- GO accepted at cycle t: o_increment=START and o_busy=1 at t+1.
- Every sweep value is held exactly DWELL+1 cycles.
- o_done asserts the cycle after the last value's hold completes, concurrent with o_busy falling.
- Async reset mid-sweep: all outputs go to reset values immediately.

## Structure
- Package `fm_sweep_pkg`: register address constants, CTRL/STATUS bit positions, state enum, reset defaults.
- Sub-module `freq_sweep_core`: FSM, shadows, dwell counter, step/clamp arithmetic. The top holds the Wishbone register file and wiring.

## Test plan
- Reset → read 0 = 100000, read 1 = 200000, o_increment = 100000, o_busy = 0.
- START=100, STOP=110, STEP=5, DWELL=0, GO → o_increment 100, 105, 110 on consecutive cycles, then o_done pulse, holds 110.
- START=110, STOP=100, STEP=4, DWELL=2 → 110, 106, 102, 100, each held 3 cycles; STATUS.dir = 1.
- BIDIR+REPEAT, 100→110 step 5 → 100, 105, 110, 105, 100, 105, 110…; ABORT → o_busy = 0 next cycle, value held, no o_done.
- STOP written mid-sweep → current pass unchanged; new STOP applies after the REPEAT restart.
- Back-to-back stb writes/reads on consecutive cycles → one ack per stb, read data correct; async reset mid-sweep → o_increment = 100000 immediately.

Source files
------------

// File: rtl/fm_sweep_pkg.sv
// Shared constants for the Wishbone frequency-sweep block: register map,
// control/status bit positions, sweep states and reset defaults.
package fm_sweep_pkg;

  localparam logic [2:0] ADDR_START  = 3'd0;
  localparam logic [2:0] ADDR_STOP   = 3'd1;
  localparam logic [2:0] ADDR_STEP   = 3'd2;
  localparam logic [2:0] ADDR_DWELL  = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_CUR    = 3'd6;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_REPEAT = 1;
  localparam int CTRL_BIDIR  = 2;
  localparam int CTRL_ABORT  = 3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DIR   = 1;
  localparam int STAT_DWELL = 2;

  localparam int          DEF_INC_W     = 31;
  localparam int          DEF_DWELL_W   = 16;
  localparam int unsigned DEF_START_RST = 100000;
  localparam int unsigned DEF_STOP_RST  = 200000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/freq_sweep_core.sv
// Sweep engine: shadowed sweep parameters, dwell counter and clamped
// step arithmetic producing the registered DDS phase increment.
module freq_sweep_core
  import fm_sweep_pkg::*;
#(
  parameter int          INC_W     = DEF_INC_W,
  parameter int          DWELL_W   = DEF_DWELL_W,
  parameter int unsigned START_RST = DEF_START_RST
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               go,
  input  logic               abort,
  input  logic               repeat_en,
  input  logic               bidir,
  input  logic               ld_start,
  input  logic [INC_W-1:0]   ld_val,
  input  logic [INC_W-1:0]   start,
  input  logic [INC_W-1:0]   stop,
  input  logic [INC_W-1:0]   step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [INC_W-1:0]   cur,
  output logic               busy,
  output logic               done,
  output logic               dir
);

  sweep_state_e       state, state_n;
  logic [INC_W-1:0]   cur_n, tgt;
  logic [INC_W-1:0]   sh_start, sh_start_n, sh_stop, sh_stop_n, sh_step, sh_step_n;
  logic [DWELL_W-1:0] cnt, cnt_n, sh_dwell, sh_dwell_n;
  logic               dir_n, rev, rev_n;

  // One step from 'from' toward 'to'; a zero step or a short remainder lands on 'to'.
  function automatic logic [INC_W-1:0] toward(input logic [INC_W-1:0] from,
                                              input logic [INC_W-1:0] to,
                                              input logic [INC_W-1:0] stp);
    logic [INC_W-1:0] rem;
    rem = (to > from) ? to - from : from - to;
    if (stp == '0 || rem <= stp) return to;
    return (to > from) ? from + stp : from - stp;
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cur      <= INC_W'(START_RST);
      dir      <= 1'b0;
      rev      <= 1'b0;
      cnt      <= '0;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      dir      <= dir_n;
      rev      <= rev_n;
      cnt      <= cnt_n;
      sh_start <= sh_start_n;
      sh_stop  <= sh_stop_n;
      sh_step  <= sh_step_n;
      sh_dwell <= sh_dwell_n;
    end
  end

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    dir_n      = dir;
    rev_n      = rev;
    cnt_n      = cnt;
    sh_start_n = sh_start;
    sh_stop_n  = sh_stop;
    sh_step_n  = sh_step;
    sh_dwell_n = sh_dwell;
    tgt        = rev ? sh_start : sh_stop;

    unique case (state)
      ST_IDLE: if (ld_start) cur_n = ld_val;
      ST_DWELL: begin
        if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (cur != tgt) begin
          cur_n = toward(cur, tgt, sh_step);
          cnt_n = sh_dwell;
        end else if (bidir && !rev) begin
          // Turn around on the peak without repeating it.
          rev_n = 1'b1;
          dir_n = ~dir;
          cur_n = toward(cur, sh_start, sh_step);
          cnt_n = sh_dwell;
        end else if (repeat_en) begin
          sh_start_n = start;
          sh_stop_n  = stop;
          sh_step_n  = step;
          sh_dwell_n = dwell;
          rev_n      = 1'b0;
          dir_n      = (stop < start);
          cur_n      = bidir ? toward(start, stop, step) : start;
          cnt_n      = dwell;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    if (abort) begin
      state_n = ST_IDLE;
      cur_n   = cur;
    end else if (go) begin
      state_n    = ST_DWELL;
      cur_n      = start;
      dir_n      = (stop < start);
      rev_n      = 1'b0;
      cnt_n      = dwell;
      sh_start_n = start;
      sh_stop_n  = stop;
      sh_step_n  = step;
      sh_dwell_n = dwell;
    end
  end

  assign busy = (state == ST_DWELL);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/fm_sweep_wb_slave.sv
// Wishbone register file for the carrier frequency sweep; doubles as the
// plain carrier-frequency register when no sweep is running.
module fm_sweep_wb_slave
  import fm_sweep_pkg::*;
#(
  parameter int          INC_W     = DEF_INC_W,
  parameter int          DWELL_W   = DEF_DWELL_W,
  parameter int unsigned START_RST = DEF_START_RST,
  parameter int unsigned STOP_RST  = DEF_STOP_RST
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [2:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  output logic             o_wb_ack,
  output logic             o_wb_stall,
  output logic [31:0]      o_wb_data,
  output logic [INC_W-1:0] o_increment,
  output logic             o_busy,
  output logic             o_done
);

  logic [INC_W-1:0]   start_r, stop_r, step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               repeat_r, bidir_r;
  logic               wr, go, abort, ld_start, dir;
  logic [31:0]        rd_mux;
  logic               unused;

  assign wr       = i_wb_cyc & i_wb_stb & i_wb_we;
  assign go       = wr && (i_wb_addr == ADDR_CTRL) && i_wb_data[CTRL_GO];
  assign abort    = wr && (i_wb_addr == ADDR_CTRL) && i_wb_data[CTRL_ABORT];
  assign ld_start = wr && (i_wb_addr == ADDR_START);
  assign o_wb_stall = 1'b0;
  assign unused   = &{1'b0, i_wb_data};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      start_r   <= INC_W'(START_RST);
      stop_r    <= INC_W'(STOP_RST);
      step_r    <= INC_W'(1);
      dwell_r   <= '0;
      repeat_r  <= 1'b0;
      bidir_r   <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= i_wb_stb;
      o_wb_data <= rd_mux;
      if (wr) begin
        case (i_wb_addr)
          ADDR_START: start_r <= i_wb_data[INC_W-1:0];
          ADDR_STOP:  stop_r  <= i_wb_data[INC_W-1:0];
          ADDR_STEP:  step_r  <= i_wb_data[INC_W-1:0];
          ADDR_DWELL: dwell_r <= i_wb_data[DWELL_W-1:0];
          ADDR_CTRL: begin
            repeat_r <= i_wb_data[CTRL_REPEAT];
            bidir_r  <= i_wb_data[CTRL_BIDIR];
          end
          default: ;
        endcase
      end
    end
  end

  // GO and ABORT are strobes and never read back.
  always_comb begin
    rd_mux = '0;
    case (i_wb_addr)
      ADDR_START: rd_mux = 32'(start_r);
      ADDR_STOP:  rd_mux = 32'(stop_r);
      ADDR_STEP:  rd_mux = 32'(step_r);
      ADDR_DWELL: rd_mux = 32'(dwell_r);
      ADDR_CTRL: begin
        rd_mux[CTRL_REPEAT] = repeat_r;
        rd_mux[CTRL_BIDIR]  = bidir_r;
      end
      ADDR_STATUS: begin
        rd_mux[STAT_BUSY]  = o_busy;
        rd_mux[STAT_DIR]   = dir;
        rd_mux[STAT_DWELL] = o_busy;
      end
      ADDR_CUR: rd_mux = 32'(o_increment);
      default: ;
    endcase
  end

  freq_sweep_core #(
    .INC_W    (INC_W),
    .DWELL_W  (DWELL_W),
    .START_RST(START_RST)
  ) u_core (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .go       (go),
    .abort    (abort),
    .repeat_en(repeat_r),
    .bidir    (bidir_r),
    .ld_start (ld_start),
    .ld_val   (i_wb_data[INC_W-1:0]),
    .start    (start_r),
    .stop     (stop_r),
    .step     (step_r),
    .dwell    (dwell_r),
    .cur      (o_increment),
    .busy     (o_busy),
    .done     (o_done),
    .dir      (dir)
  );

endmodule

// File: tb/tb_fm_sweep_wb_slave.sv
// Directed bench for fm_sweep_wb_slave: a list-of-values sweep model feeds a
// per-cycle expectation queue checked on every falling edge.
`timescale 1ns/1ps
module tb_fm_sweep_wb_slave;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [2:0]  i_wb_addr = '0;
  logic [31:0] i_wb_data = '0;
  logic        o_wb_ack, o_wb_stall, o_busy, o_done;
  logic [31:0] o_wb_data;
  logic [30:0] o_increment;

  fm_sweep_wb_slave dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_increment(o_increment), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int unsigned inc; bit busy; bit done; } exp_t;
  exp_t        exp_q[$];
  exp_t        cur_e;
  int unsigned vals[$];
  int unsigned breq[4];
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      cur_e = exp_q.pop_front();
      chk("increment", 32'(o_increment), cur_e.inc);
      chk("busy", 32'(o_busy), 32'(cur_e.busy));
      chk("done", 32'(o_done), 32'(cur_e.done));
    end
  end

  // Sweep values from a to b (inclusive) in steps of s, last step clamped.
  task automatic add_leg(input int unsigned a, input int unsigned b,
                         input int unsigned s, input bit skip_first);
    int unsigned v;
    int unsigned d;
    v = a;
    if (!skip_first) vals.push_back(v);
    while (v != b) begin
      d = (b > a) ? b - v : v - b;
      v = (s == 0 || d <= s) ? b : ((b > a) ? v + s : v - s);
      vals.push_back(v);
    end
  endtask

  task automatic push_full(input int dwell);
    foreach (vals[i]) repeat (dwell + 1) exp_q.push_back('{vals[i], 1'b1, 1'b0});
    exp_q.push_back('{vals[vals.size()-1], 1'b0, 1'b1});
    exp_q.push_back('{vals[vals.size()-1], 1'b0, 1'b0});
  endtask

  task automatic push_abort(input int dwell, input int ncyc);
    int k;
    int unsigned last;
    k = 0;
    last = 0;
    foreach (vals[i])
      repeat (dwell + 1)
        if (k < ncyc) begin
          exp_q.push_back('{vals[i], 1'b1, 1'b0});
          last = vals[i];
          k++;
        end
    repeat (3) exp_q.push_back('{last, 1'b0, 1'b0});
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    chk("write ack", 32'(o_wb_ack), 1);
  endtask

  task automatic wb_read(input logic [2:0] a, input logic [31:0] req, input string name);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    chk("read ack", 32'(o_wb_ack), 1);
    chk(name, o_wb_data, req);
  endtask

  task automatic run_go(input int unsigned st, input int unsigned sp, input int unsigned stp,
                        input int unsigned dw, input logic [31:0] ctrl);
    wb_write(3'd0, st);
    wb_write(3'd1, sp);
    wb_write(3'd2, stp);
    wb_write(3'd3, dw);
    vals.delete();
    wb_write(3'd4, ctrl);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge i_clk);
      n++;
    end
    chk("expectation queue drained", exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #23 i_reset = 1'b0;
    @(posedge i_clk); #1;

    // Reset state
    chk("reset increment", 32'(o_increment), 100000);
    chk("reset busy", 32'(o_busy), 0);
    chk("reset done", 32'(o_done), 0);
    chk("reset ack", 32'(o_wb_ack), 0);
    chk("stall", 32'(o_wb_stall), 0);
    wb_read(3'd0, 100000, "reset START");
    wb_read(3'd1, 200000, "reset STOP");
    wb_read(3'd2, 1, "reset STEP");
    wb_read(3'd3, 0, "reset DWELL");
    wb_read(3'd4, 0, "reset CTRL");
    wb_read(3'd6, 100000, "reset CUR");
    chk("ack drops", 32'(o_wb_ack), 1);
    @(posedge i_clk); #1;
    chk("ack after idle cycle", 32'(o_wb_ack), 0);

    // Up sweep, no dwell
    run_go(100, 110, 5, 0, 32'h1);
    add_leg(100, 110, 5, 1'b0);
    push_full(0);
    wait_drain();
    chk("up final held", 32'(o_increment), 110);
    wb_read(3'd4, 0, "CTRL GO self-clears");

    // Down sweep with dwell 2 and clamped last step
    run_go(110, 100, 4, 2, 32'h1);
    add_leg(110, 100, 4, 1'b0);
    push_full(2);
    wb_read(3'd5, 7, "STATUS busy/dir/dwell");
    wb_read(3'd6, 110, "CUR during sweep");
    wait_drain();
    chk("down final held", 32'(o_increment), 100);
    wb_read(3'd5, 2, "STATUS idle");

    // Legacy fixed-frequency load, ignored writes, unused address
    wb_write(3'd0, 500);
    chk("legacy START load", 32'(o_increment), 500);
    wb_write(3'd7, 32'hFFFF);
    wb_write(3'd5, 32'hFFFF);
    wb_read(3'd7, 0, "addr 7 reads 0");
    wb_read(3'd5, 2, "STATUS write ignored");

    // ABORT+GO together: abort wins
    wb_write(3'd4, 32'h9);
    chk("abort+go busy", 32'(o_busy), 0);
    chk("abort+go inc", 32'(o_increment), 500);

    // Bidirectional repeat, then abort
    run_go(100, 110, 5, 1, 32'h7);
    add_leg(100, 110, 5, 1'b0);
    add_leg(110, 100, 5, 1'b1);
    add_leg(100, 110, 5, 1'b1);
    add_leg(110, 100, 5, 1'b1);
    push_abort(1, 15);
    repeat (14) @(posedge i_clk);
    #1;
    wb_write(3'd4, 32'h8);
    chk("abort busy", 32'(o_busy), 0);
    chk("abort done", 32'(o_done), 0);
    wait_drain();
    chk("abort held value", 32'(o_increment), 105);

    // STOP changed mid-pass applies only after the repeat restart
    run_go(100, 110, 5, 0, 32'h3);
    add_leg(100, 110, 5, 1'b0);
    add_leg(100, 120, 5, 1'b0);
    add_leg(100, 120, 5, 1'b0);
    push_abort(0, 9);
    wb_write(3'd1, 120);
    repeat (7) @(posedge i_clk);
    #1;
    wb_write(3'd4, 32'h8);
    wait_drain();
    chk("repeat abort held", 32'(o_increment), 100);

    // Back-to-back reads, one ack per strobe
    breq = '{100, 120, 5, 0};
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_wb_addr = 3'(i);
      @(posedge i_clk); #1;
      chk("burst ack", 32'(o_wb_ack), 1);
      chk("burst data", o_wb_data, breq[i]);
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    chk("burst ack end", 32'(o_wb_ack), 0);

    // START == STOP: single value held DWELL+1 cycles
    run_go(300, 300, 7, 3, 32'h1);
    add_leg(300, 300, 7, 1'b0);
    push_full(3);
    wait_drain();
    chk("equal final", 32'(o_increment), 300);

    // Async reset mid-sweep
    run_go(100, 200, 1, 50, 32'h1);
    repeat (20) @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    chk("async reset inc", 32'(o_increment), 100000);
    chk("async reset busy", 32'(o_busy), 0);
    chk("async reset ack", 32'(o_wb_ack), 0);
    @(negedge i_clk) i_reset = 1'b0;
    @(posedge i_clk); #1;
    wb_read(3'd0, 100000, "START after reset");
    wb_read(3'd1, 200000, "STOP after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
